// File: rtl/button_level_gen.sv
// Turns 1-cycle request pulses into fixed-width press levels with a fixed minimum gap.
// Optional: BUTTON_LEVEL_RETRIG_EN makes a request during HOLD extend the current press.
module button_level_gen #(
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 4,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p,
  input  logic              clr_ovf,
  output logic              l,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               l_q, l_d;
  logic               busy_q, busy_d;
  logic               enq_s;
  logic               deq_s;

  // Next-state, queue bookkeeping and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~clr_ovf;
    enq_s   = 1'b0;
    deq_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (p) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
`ifdef BUTTON_LEVEL_RETRIG_EN
        if (p) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
`else
        enq_s = p;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
`endif
      end
      GAP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
          enq_s = p;
        end else if (pend_q != PEND_ZERO) begin
          // Queued press goes first; a same-cycle request takes its slot
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          deq_s   = 1'b1;
          enq_s   = p;
        end else if (p) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    if (enq_s && !deq_s) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (deq_s && !enq_s) begin
      pend_d = pend_q - PEND_ONE;
    end else begin
      pend_d = pend_q;
    end

    l_d    = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      pend_q  <= PEND_ZERO;
      ovf_q   <= 1'b0;
      l_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
    end
  end

  assign l    = l_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_button_level_gen.sv
// Scoreboard bench for button_level_gen (HOLD_CYC=8, GAP_CYC=4, PEND_W=2).
module tb_button_level_gen;

  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int PW   = 2;
  localparam int MAXP = 3;

  logic          clk;
  logic          rst;
  logic          p;
  logic          clr_ovf;
  logic          l;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  typedef struct packed {
    logic          l;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_vec;
  int n_err;
  int m_phase;
  int m_left;
  int m_pend;
  int m_ovf;
  int presses;
  int cur_run;
  int max_run;
  logic prev_l;

  button_level_gen #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .p(p), .clr_ovf(clr_ovf),
    .l(l), .busy(busy), .pend(pend), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_pend  = 0;
    m_ovf   = 0;
  endtask

  // Reference: m_left counts the cycles remaining in the current phase, this one included
  task automatic model_step(input logic pi, input logic ci);
    int add;
    int take;
    add  = 0;
    take = 0;
    if (ci) m_ovf = 0;
    case (m_phase)
      0: if (pi) begin m_phase = 1; m_left = HOLD; end
      1: begin
        add = pi;
`ifdef BUTTON_LEVEL_RETRIG_EN
        if (pi) begin add = 0; m_left = HOLD + 1; end
`endif
        if (m_left == 1) begin m_phase = 2; m_left = GAP; end
        else m_left--;
      end
      default: begin
        if (m_left > 1) begin m_left--; add = pi; end
        else if (m_pend > 0) begin take = 1; add = pi; m_phase = 1; m_left = HOLD; end
        else if (pi) begin m_phase = 1; m_left = HOLD; end
        else m_phase = 0;
      end
    endcase
    if (add == 1 && take == 0) begin
      if (m_pend == MAXP) m_ovf = 1;
      else m_pend++;
    end else if (take == 1 && add == 0) begin
      m_pend--;
    end
  endtask

  task automatic step(input logic pi, input logic ci);
    exp_t e;
    p       = pi;
    clr_ovf = ci;
    model_step(pi, ci);
    e.l    = (m_phase == 1);
    e.busy = (m_phase != 0);
    e.pend = PW'(m_pend);
    e.ovf  = (m_ovf != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    e = sb_q.pop_front();
    check_eq("l", int'(l), int'(e.l));
    check_eq("busy", int'(busy), int'(e.busy));
    check_eq("pend", int'(pend), int'(e.pend));
    check_eq("ovf", int'(ovf), int'(e.ovf));
    if (l && !prev_l) presses++;
    if (l) cur_run++;
    else cur_run = 0;
    if (cur_run > max_run) max_run = cur_run;
    prev_l = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    presses = 0;
    cur_run = 0;
    max_run = 0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    p       = 1'b0;
    clr_ovf = 1'b0;
    prev_l  = 1'b0;
    model_reset();
    clear_stats();

    // Reset held while p toggles
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      p       = i[0];
      clr_ovf = ~i[0];
      @(posedge clk);
      #2;
      check_eq("rst_l", int'(l), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_pend", int'(pend), 0);
      check_eq("rst_ovf", int'(ovf), 0);
      @(negedge clk);
    end
    p       = 1'b0;
    clr_ovf = 1'b0;
    rst     = 1'b1;
    idle(3);
    check_eq("post_rst_presses", presses, 0);

    // Single press: 8 high, 4 low busy, then idle
    clear_stats();
    step(1'b1, 1'b0);
    idle(20);
    check_eq("single_presses", presses, 1);
    check_eq("single_width", max_run, HOLD);

    // Three queued during first HOLD
    clear_stats();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(60);
    check_eq("queue3_presses", presses, 4);
    check_eq("queue3_width", max_run, HOLD);

    // Overflow, clear, and clear colliding with a drop
    clear_stats();
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    idle(60);
    check_eq("ovf_presses", presses, 4);

    // Async reset in the 3rd HOLD cycle with two queued
    clear_stats();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst_l", int'(l), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_pend", int'(pend), 0);
    check_eq("arst_ovf", int'(ovf), 0);
    model_reset();
    prev_l = 1'b0;
    cur_run = 0;
    @(negedge clk);
    rst = 1'b1;
    presses = 0;
    idle(40);
    check_eq("arst_no_replay", presses, 0);

    // Request in the 5th HOLD cycle
    clear_stats();
    step(1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0);
    idle(40);
`ifdef BUTTON_LEVEL_RETRIG_EN
    check_eq("retrig_width", max_run, HOLD + 5);
    check_eq("retrig_presses", presses, 1);
`else
    check_eq("hold5_width", max_run, HOLD);
    check_eq("hold5_presses", presses, 2);
`endif

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
